// File: rtl/bram_avalon_slave.sv
// bram_avalon_slave
// Avalon-MM pipelined slave in front of an inferred single-port RAM of 2**DEPTH_LOG2 x 32-bit
// words. Optionally zero-fills the whole array after reset (INIT state) before accepting
// commands. Reads have a fixed latency of 2: a read accepted at edge N has its RAM word
// registered at N+1 and s_readdata / s_readdatavalid updated at N+2.
//
// Optional feature: define BRAM_SLAVE_ADDR_CHECK_EN to add s_err_count and reject accesses
// whose address bits above the array are non-zero (writes dropped, reads return 32'hDEADBEEF).
// Without the macro, those upper address bits are ignored and the array aliases.
//
// Ports
//   clk_clk          in   clock
//   clk_reset_reset  in   synchronous active-high reset
//   s_address        in   byte address; word index = s_address[DEPTH_LOG2+1:2]
//   s_read/s_write   in   command strobes (both high: write wins, read dropped)
//   s_writedata      in   write data
//   s_byteenable     in   per-byte write enable
//   s_readdata       out  read data, valid with s_readdatavalid
//   s_waitrequest    out  1 = command this cycle not accepted
//   s_readdatavalid  out  one-cycle strobe per accepted read
//   s_err_count      out  saturating out-of-range access count (BRAM_SLAVE_ADDR_CHECK_EN only)
module bram_avalon_slave #(
    parameter int unsigned DEPTH_LOG2     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_clk,
    input  logic        clk_reset_reset,
    input  logic [31:0] s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic [3:0]  s_byteenable,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic        s_readdatavalid
`ifdef BRAM_SLAVE_ADDR_CHECK_EN
    ,
    output logic [15:0] s_err_count
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_q;
    logic [31:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  oor;
    logic                  cmd_ok;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  unused_addr;

    logic                  rd_v0_q, rd_v1_q;
    logic                  rd_oor0_q, rd_oor1_q;
    logic [DEPTH_LOG2-1:0] rd_idx_q;
    logic [31:0]           ram_q;

    assign idx         = s_address[DEPTH_LOG2+1:2];
    assign unused_addr = ^s_address;

`ifdef BRAM_SLAVE_ADDR_CHECK_EN
    assign oor = |s_address[31:DEPTH_LOG2+2];
`else
    assign oor = 1'b0;
`endif

    // Reset is synchronous, so gate acceptance explicitly while it is held.
    assign cmd_ok = ~s_waitrequest & ~clk_reset_reset;
    assign rd_acc = cmd_ok & s_read & ~s_write;
    assign wr_acc = cmd_ok & s_write & ~oor;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_clk) begin
        if (clk_reset_reset) begin
            state_q <= CLEAR_ON_RESET ? StInit : StReady;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (&clr_q) state_d = StReady;
            StReady: state_d = StReady;
            default: state_d = StReady;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        s_waitrequest = 1'b1;
        unique case (state_q)
            StInit:  s_waitrequest = 1'b1;
            StReady: s_waitrequest = 1'b0;
            default: s_waitrequest = 1'b1;
        endcase
    end

    // Clear sweep pointer: one word per INIT cycle, restarts at 0 on every reset.
    always_ff @(posedge clk_clk) begin
        if (clk_reset_reset) begin
            clr_q <= '0;
        end else if (state_q == StInit) begin
            clr_q <= clr_q + 1'b1;
        end
    end

    // RAM array: no reset on the storage itself.
    always_ff @(posedge clk_clk) begin
        if (state_q == StInit) begin
            mem[clr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (s_byteenable[i]) begin
                    mem[idx][8*i +: 8] <= s_writedata[8*i +: 8];
                end
            end
        end
        // Read uses the pre-write value, so a write accepted in the same edge as this RAM
        // fetch (i.e. issued after the read) does not leak into the older read.
        if (rd_v0_q) begin
            ram_q <= mem[rd_idx_q];
        end
    end

    // Read pipeline: address stage, RAM stage, output stage.
    always_ff @(posedge clk_clk) begin
        if (clk_reset_reset) begin
            rd_v0_q         <= 1'b0;
            rd_v1_q         <= 1'b0;
            rd_oor0_q       <= 1'b0;
            rd_oor1_q       <= 1'b0;
            rd_idx_q        <= '0;
            s_readdatavalid <= 1'b0;
            s_readdata      <= '0;
        end else begin
            rd_v0_q         <= rd_acc;
            rd_oor0_q       <= oor;
            rd_idx_q        <= idx;
            rd_v1_q         <= rd_v0_q;
            rd_oor1_q       <= rd_oor0_q;
            s_readdatavalid <= rd_v1_q;
            if (rd_v1_q) begin
                s_readdata <= rd_oor1_q ? 32'hDEADBEEF : ram_q;
            end
        end
    end

`ifdef BRAM_SLAVE_ADDR_CHECK_EN
    always_ff @(posedge clk_clk) begin
        if (clk_reset_reset) begin
            s_err_count <= '0;
        end else if (cmd_ok && (s_read || s_write) && oor && (s_err_count != 16'hFFFF)) begin
            s_err_count <= s_err_count + 16'd1;
        end
    end
`endif

endmodule
